sync_fifo_ctrl: RTL and testbench

Parametrised single-clock FIFO with occupancy count, programmable almost-full/almost-empty thresholds, one-cycle error pulses and a selectable read mode: standard registered read or first-word-fall-through (FWFT). It is the general-purpose buffering block between producer and consumer stages in the same clock domain. It supersedes the earlier fixed-size, unclocked FIFO.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_ram.sv | 24 ++
 rtl/sync_fifo_ctrl.sv | 109 ++++++++++
 tb/tb_sync_fifo_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: read-mode selectors and a
// width helper used to size pointers and the occupancy count.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH storage: one synchronous write port, one asynchronous read port.
// Contents are never reset; the controller tracks which entries are live.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: wrap-around pointers, occupancy count, flags,
// one-cycle error pulses, and either a registered or fall-through read port.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 16,
  parameter  int AFULL_TH  = DEPTH - 2,
  parameter  int AEMPTY_TH = 2,
  parameter  int FWFT      = 0,
  localparam int CW        = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = clog2(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] ram_rdata;
  logic             wr_acc;
  logic             rd_acc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Flags come only from the registered count, so they are glitch-free.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AFULL_TH));
  assign almost_empty = (count <= CW'(AEMPTY_TH));

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc && !clr),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  if (FWFT == FIFO_FWFT) begin : g_fwft
    // Head word is presented combinationally; masked to zero while empty.
    assign rd_data  = empty ? '0 : ram_rdata;
    assign rd_valid = !empty;
  end else begin : g_std
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else if (clr) begin
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: three configurations (16-deep standard, 5-deep
// standard, 16-deep FWFT) checked each cycle against a queue model.
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] clr_v = '0;
  logic [2:0] wr_en_v = '0;
  logic [2:0] rd_en_v = '0;
  logic [7:0] wd [3];
  logic [7:0] rdd [3];
  logic [2:0] rdv_v, full_v, empty_v, af_v, ae_v, ovf_v, unf_v;
  logic [4:0] cnt0, cnt2;
  logic [2:0] cnt1;
  logic [4:0] cnt_w [3];

  int checks = 0;
  int errors = 0;

  localparam int MD [3] = '{16, 5, 16};
  localparam int MAF [3] = '{14, 3, 14};
  localparam int MAE [3] = '{2, 2, 2};
  localparam int MFW [3] = '{0, 0, 1};

  always #5 clk = ~clk;

  assign cnt_w[0] = cnt0;
  assign cnt_w[1] = {2'b00, cnt1};
  assign cnt_w[2] = cnt2;

  sync_fifo_ctrl #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr_v[0]), .wr_en(wr_en_v[0]), .wr_data(wd[0]),
    .rd_en(rd_en_v[0]), .rd_data(rdd[0]), .rd_valid(rdv_v[0]), .full(full_v[0]),
    .empty(empty_v[0]), .almost_full(af_v[0]), .almost_empty(ae_v[0]), .count(cnt0),
    .overflow(ovf_v[0]), .underflow(unf_v[0]));

  sync_fifo_ctrl #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr_v[1]), .wr_en(wr_en_v[1]), .wr_data(wd[1]),
    .rd_en(rd_en_v[1]), .rd_data(rdd[1]), .rd_valid(rdv_v[1]), .full(full_v[1]),
    .empty(empty_v[1]), .almost_full(af_v[1]), .almost_empty(ae_v[1]), .count(cnt1),
    .overflow(ovf_v[1]), .underflow(unf_v[1]));

  sync_fifo_ctrl #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .clr(clr_v[2]), .wr_en(wr_en_v[2]), .wr_data(wd[2]),
    .rd_en(rd_en_v[2]), .rd_data(rdd[2]), .rd_valid(rdv_v[2]), .full(full_v[2]),
    .empty(empty_v[2]), .almost_full(af_v[2]), .almost_empty(ae_v[2]), .count(cnt2),
    .overflow(ovf_v[2]), .underflow(unf_v[2]));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of live words plus the expected output registers.
  logic [7:0] mq [3][$];
  logic [7:0] m_rdata [3];
  logic       m_rvld [3];
  logic       m_ovf [3];
  logic       m_unf [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        mq[i].delete();
        m_rdata[i] = '0;
        m_rvld[i]  = 1'b0;
        m_ovf[i]   = 1'b0;
        m_unf[i]   = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int  n;
        bit  f, e, wa, ra;
        n = mq[i].size();
        f = (n == MD[i]);
        e = (n == 0);
        if (clr_v[i]) begin
          mq[i].delete();
          m_rvld[i] = 1'b0;
          m_ovf[i]  = 1'b0;
          m_unf[i]  = 1'b0;
        end else begin
          wa = wr_en_v[i] && !f;
          ra = rd_en_v[i] && !e;
          m_rvld[i] = ra;
          if (ra) m_rdata[i] = mq[i].pop_front();
          if (wa) mq[i].push_back(wd[i]);
          m_ovf[i] = wr_en_v[i] && f;
          m_unf[i] = rd_en_v[i] && e;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int n;
      n = mq[i].size();
      check($sformatf("u%0d count", i), int'(cnt_w[i]), n);
      check($sformatf("u%0d full", i), int'(full_v[i]), int'(n == MD[i]));
      check($sformatf("u%0d empty", i), int'(empty_v[i]), int'(n == 0));
      check($sformatf("u%0d almost_full", i), int'(af_v[i]), int'(n >= MAF[i]));
      check($sformatf("u%0d almost_empty", i), int'(ae_v[i]), int'(n <= MAE[i]));
      check($sformatf("u%0d overflow", i), int'(ovf_v[i]), int'(m_ovf[i]));
      check($sformatf("u%0d underflow", i), int'(unf_v[i]), int'(m_unf[i]));
      if (MFW[i] == 1) begin
        check($sformatf("u%0d rd_valid", i), int'(rdv_v[i]), int'(n != 0));
        if (n != 0) check($sformatf("u%0d rd_data", i), int'(rdd[i]), int'(mq[i][0]));
      end else begin
        check($sformatf("u%0d rd_valid", i), int'(rdv_v[i]), int'(m_rvld[i]));
        check($sformatf("u%0d rd_data", i), int'(rdd[i]), int'(m_rdata[i]));
      end
    end
  end

  // One cycle of requests on instance i; returns at posedge+1 with inputs idle.
  task automatic step(input int i, input bit w, input bit r, input logic [7:0] d, input bit c);
    wr_en_v[i] = w;
    rd_en_v[i] = r;
    wd[i]      = d;
    clr_v[i]   = c;
    @(posedge clk);
    #1;
    wr_en_v[i] = 1'b0;
    rd_en_v[i] = 1'b0;
    clr_v[i]   = 1'b0;
  endtask

  logic [7:0] got [$];

  initial begin
    for (int i = 0; i < 3; i++) wd[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset empty", int'(empty_v), 7);
    check("reset almost_empty", int'(ae_v), 7);
    check("reset full", int'(full_v), 0);
    check("reset cnt0", int'(cnt0), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill the 16-deep FIFO, then one refused write.
    for (int k = 0; k < 16; k++) begin
      step(0, 1, 0, 8'(k), 0);
      if (k == 12) check("af at 13", int'(af_v[0]), 0);
      if (k == 13) check("af at 14", int'(af_v[0]), 1);
    end
    check("fill count", int'(cnt0), 16);
    check("fill full", int'(full_v[0]), 1);
    step(0, 1, 0, 8'hAA, 0);
    check("overflow pulse", int'(ovf_v[0]), 1);
    check("overflow count", int'(cnt0), 16);
    step(0, 0, 0, 8'h00, 0);
    check("overflow clears", int'(ovf_v[0]), 0);

    // Drain in standard mode, then one refused read.
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 1, 8'h00, 0);
      check("drain data", int'(rdd[0]), k);
      check("drain valid", int'(rdv_v[0]), 1);
    end
    step(0, 0, 1, 8'h00, 0);
    check("underflow pulse", int'(unf_v[0]), 1);
    check("underflow empty", int'(empty_v[0]), 1);
    check("underflow no valid", int'(rdv_v[0]), 0);
    step(0, 0, 0, 8'h00, 0);

    // DEPTH=5: simultaneous traffic at count 3 forces pointer wrap.
    for (int k = 0; k < 3; k++) step(1, 1, 0, 8'(8'h10 + k), 0);
    for (int k = 3; k < 12; k++) begin
      step(1, 1, 1, 8'(8'h10 + k), 0);
      if (rdv_v[1]) got.push_back(rdd[1]);
      if (k == 4) check("u1 count steady", int'(cnt1), 3);
    end
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 1, 8'h00, 0);
      if (rdv_v[1]) got.push_back(rdd[1]);
    end
    check("u1 reads", got.size(), 12);
    for (int k = 0; k < got.size(); k++) check("u1 order", int'(got[k]), 8'h10 + k);

    step(1, 1, 1, 8'h20, 0);
    check("u1 wr+rd empty count", int'(cnt1), 1);
    check("u1 wr+rd empty unf", int'(unf_v[1]), 1);
    for (int k = 1; k < 5; k++) step(1, 1, 0, 8'(8'h20 + k), 0);
    check("u1 full", int'(full_v[1]), 1);
    step(1, 1, 1, 8'h25, 0);
    check("u1 wr+rd full count", int'(cnt1), 4);
    check("u1 wr+rd full ovf", int'(ovf_v[1]), 1);
    check("u1 wr+rd full data", int'(rdd[1]), 8'h20);
    for (int k = 0; k < 4; k++) step(1, 0, 1, 8'h00, 0);

    // FWFT: word appears without a read request.
    step(2, 1, 0, 8'h5A, 0);
    check("fwft data", int'(rdd[2]), 8'h5A);
    check("fwft valid", int'(rdv_v[2]), 1);
    step(2, 0, 0, 8'h00, 0);
    check("fwft hold", int'(rdd[2]), 8'h5A);
    step(2, 0, 1, 8'h00, 0);
    check("fwft popped empty", int'(empty_v[2]), 1);
    check("fwft popped valid", int'(rdv_v[2]), 0);

    // Flush with concurrent requests.
    for (int k = 0; k < 7; k++) step(0, 1, 0, 8'(8'h30 + k), 0);
    check("pre-clr count", int'(cnt0), 7);
    step(0, 1, 1, 8'h77, 1);
    check("clr count", int'(cnt0), 0);
    check("clr empty", int'(empty_v[0]), 1);
    check("clr ovf", int'(ovf_v[0]), 0);
    check("clr unf", int'(unf_v[0]), 0);
    check("clr valid", int'(rdv_v[0]), 0);
    step(0, 1, 0, 8'h40, 0);
    step(0, 0, 1, 8'h00, 0);
    check("post-clr data", int'(rdd[0]), 8'h40);

    // Asynchronous reset in the middle of a burst.
    for (int k = 0; k < 3; k++) step(0, 1, 0, 8'(8'h50 + k), 0);
    step(0, 1, 1, 8'h53, 0);
    step(2, 1, 0, 8'h66, 0);
    wr_en_v[0] = 1'b1;
    wd[0]      = 8'h54;
    #3;
    rst_n = 1'b0;
    #1;
    check("rst count", int'(cnt0), 0);
    check("rst empty", int'(empty_v), 7);
    check("rst full", int'(full_v[0]), 0);
    check("rst af", int'(af_v[0]), 0);
    check("rst ae", int'(ae_v[0]), 1);
    check("rst rd_data", int'(rdd[0]), 0);
    check("rst rd_valid", int'(rdv_v), 0);
    check("rst ovf", int'(ovf_v[0]), 0);
    check("rst unf", int'(unf_v[0]), 0);
    wr_en_v[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 1, 0, 8'h61, 0);
    step(0, 0, 1, 8'h00, 0);
    check("post-rst data", int'(rdd[0]), 8'h61);
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
